// File: rtl/phys_free_list_ctrl.sv
// Rename-stage free list: a circular buffer of free physical tags with in-order multi-slot
// allocation, retire-time frees, and a retired head used to restore the pool on flush.
module phys_free_list_ctrl #(
  parameter int SS = 2,
  parameter int NUM_PREGS = 64,
  parameter int NUM_AREGS = 32,
  localparam int DEPTH = NUM_PREGS - NUM_AREGS,
  localparam int PW = $clog2(NUM_PREGS),
  localparam int IW = $clog2(DEPTH),
  localparam int CW = IW + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SS-1:0]          alloc_req,
  output logic [SS-1:0]          alloc_gnt,
  output logic [SS-1:0][PW-1:0]  alloc_preg,
  input  logic [SS-1:0]          retire_push,
  input  logic [SS-1:0][PW-1:0]  retire_preg,
  input  logic [SS-1:0]          retire_adv,
  input  logic                   flush,
  output logic [CW-1:0]          free_count,
  output logic                   empty
);

  logic [PW-1:0]         ring [DEPTH];
  logic [CW-1:0]         head;
  logic [CW-1:0]         tail;
  logic [CW-1:0]         rhead;
  logic [CW-1:0]         n_req;
  logic [CW-1:0]         gnt_cnt;
  logic [CW-1:0]         push_cnt;
  logic [CW-1:0]         adv_cnt;
  logic [CW-1:0]         room;
  logic [SS-1:0]         wr_en;
  logic [SS-1:0][IW-1:0] wr_idx;

  // Grants are monotonic in n_req, so a denied slot automatically stalls every younger slot.
  always_comb begin
    n_req      = '0;
    gnt_cnt    = '0;
    alloc_gnt  = '0;
    alloc_preg = '0;
    for (int i = 0; i < SS; i++) begin
      if (alloc_req[i]) begin
        n_req = n_req + CW'(1);
        alloc_preg[i] = ring[IW'(head + n_req - CW'(1))];
        if (n_req <= free_count && !flush) begin
          alloc_gnt[i] = 1'b1;
          gnt_cnt = gnt_cnt + CW'(1);
        end
      end
    end
  end

  // Pushes beyond the free room are dropped so free_count never exceeds DEPTH.
  always_comb begin
    room     = CW'(DEPTH) - free_count;
    push_cnt = '0;
    wr_en    = '0;
    wr_idx   = '0;
    adv_cnt  = '0;
    for (int i = 0; i < SS; i++) begin
      if (retire_push[i] && push_cnt < room) begin
        wr_en[i]  = 1'b1;
        wr_idx[i] = IW'(tail + push_cnt);
        push_cnt  = push_cnt + CW'(1);
      end
      adv_cnt = adv_cnt + CW'(retire_adv[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      rhead      <= '0;
      free_count <= CW'(DEPTH);
      for (int k = 0; k < DEPTH; k++) begin
        ring[k] <= PW'(NUM_AREGS + k);
      end
    end else begin
      for (int i = 0; i < SS; i++) begin
        if (wr_en[i]) begin
          ring[wr_idx[i]] <= retire_preg[i];
        end
      end
      tail  <= tail + push_cnt;
      rhead <= rhead + adv_cnt;
      if (flush) begin
        head       <= rhead + adv_cnt;
        free_count <= CW'(DEPTH);
      end else begin
        head       <= head + gnt_cnt;
        free_count <= free_count + push_cnt - gnt_cnt;
      end
    end
  end

  assign empty = (free_count == '0);

endmodule

// File: tb/tb_phys_free_list_ctrl.sv
// Directed bench for phys_free_list_ctrl: hand-computed tags and counts, plus a free-set
// scoreboard across ring wrap-around.
module tb_phys_free_list_ctrl;

  logic            clk;
  logic            rst;
  logic [1:0]      alloc_req;
  logic [1:0]      alloc_gnt;
  logic [1:0][5:0] alloc_preg;
  logic [1:0]      retire_push;
  logic [1:0][5:0] retire_preg;
  logic [1:0]      retire_adv;
  logic            flush;
  logic [5:0]      free_count;
  logic            empty;

  int checks = 0;
  int errors = 0;
  logic [63:0] free_set;

  phys_free_list_ctrl #(.SS(2), .NUM_PREGS(64), .NUM_AREGS(32)) dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_preg(alloc_preg),
    .retire_push(retire_push), .retire_preg(retire_preg), .retire_adv(retire_adv),
    .flush(flush), .free_count(free_count), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] req, input logic [1:0] push, input logic [5:0] p0,
                       input logic [5:0] p1, input logic [1:0] adv, input logic fl);
    alloc_req      = req;
    retire_push    = push;
    retire_preg[0] = p0;
    retire_preg[1] = p1;
    retire_adv     = adv;
    flush          = fl;
    #1;
  endtask

  // Stimulus must never overflow the pool; checked before every edge.
  task automatic tick;
    if (!rst) begin
      chk("no_overflow", 32'(int'(free_count) + $countones(retire_push) <= 32), 32'd1);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(2'b00, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    drive(2'b00, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0);
    chk("rst_gnt", 32'(alloc_gnt), 32'd0);
    chk("rst_free", 32'(free_count), 32'd32);
    chk("rst_empty", 32'(empty), 32'd0);

    // first double alloc
    drive(2'b11, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0);
    chk("a0_gnt", 32'(alloc_gnt), 32'd3);
    chk("a0_preg0", 32'(alloc_preg[0]), 32'd32);
    chk("a0_preg1", 32'(alloc_preg[1]), 32'd33);
    tick();
    chk("a0_free", 32'(free_count), 32'd30);

    // drain the pool
    for (int k = 1; k < 16; k++) begin
      drive(2'b11, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0);
      chk("drain_gnt", 32'(alloc_gnt), 32'd3);
      chk("drain_preg0", 32'(alloc_preg[0]), 32'(32 + 2 * k));
      chk("drain_preg1", 32'(alloc_preg[1]), 32'(33 + 2 * k));
      tick();
    end
    chk("drain_free", 32'(free_count), 32'd0);
    chk("drain_empty", 32'(empty), 32'd1);
    drive(2'b11, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0);
    chk("empty_gnt", 32'(alloc_gnt), 32'd0);
    tick();

    // single free tag pushed via slot 1 only
    drive(2'b00, 2'b10, 6'd0, 6'd63, 2'b10, 1'b0);
    tick();
    chk("one_free", 32'(free_count), 32'd1);
    chk("one_empty", 32'(empty), 32'd0);
    drive(2'b11, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0);
    chk("one_gnt11", 32'(alloc_gnt), 32'd1);
    chk("one_preg0", 32'(alloc_preg[0]), 32'd63);
    drive(2'b10, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0);
    chk("one_gnt10", 32'(alloc_gnt), 32'd2);
    chk("one_preg1", 32'(alloc_preg[1]), 32'd63);
    tick();
    chk("one_free_after", 32'(free_count), 32'd0);

    // simultaneous alloc and push
    drive(2'b00, 2'b11, 6'd20, 6'd21, 2'b11, 1'b0);
    tick();
    chk("sim_free_pre", 32'(free_count), 32'd2);
    drive(2'b11, 2'b11, 6'd5, 6'd7, 2'b11, 1'b0);
    chk("sim_gnt", 32'(alloc_gnt), 32'd3);
    chk("sim_preg0", 32'(alloc_preg[0]), 32'd20);
    chk("sim_preg1", 32'(alloc_preg[1]), 32'd21);
    tick();
    chk("sim_free", 32'(free_count), 32'd2);
    drive(2'b11, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0);
    chk("sim_next_preg0", 32'(alloc_preg[0]), 32'd5);
    chk("sim_next_preg1", 32'(alloc_preg[1]), 32'd7);
    tick();
    chk("sim_next_free", 32'(free_count), 32'd0);

    // reset mid-operation with requests in flight
    drive(2'b11, 2'b11, 6'd9, 6'd10, 2'b11, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(2'b11, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0);
    chk("mid_rst_free", 32'(free_count), 32'd32);
    chk("mid_rst_preg0", 32'(alloc_preg[0]), 32'd32);
    chk("mid_rst_preg1", 32'(alloc_preg[1]), 32'd33);

    // flush: 4 allocs, 2 retire, flush, then reallocate
    tick();
    drive(2'b11, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0);
    chk("fl_a1_preg0", 32'(alloc_preg[0]), 32'd34);
    tick();
    chk("fl_free4", 32'(free_count), 32'd28);
    drive(2'b00, 2'b11, 6'd3, 6'd4, 2'b11, 1'b0);
    tick();
    chk("fl_free_ret", 32'(free_count), 32'd30);
    drive(2'b11, 2'b00, 6'd0, 6'd0, 2'b00, 1'b1);
    chk("fl_gnt", 32'(alloc_gnt), 32'd0);
    tick();
    chk("fl_free", 32'(free_count), 32'd32);
    drive(2'b11, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0);
    chk("fl_re_gnt", 32'(alloc_gnt), 32'd3);
    chk("fl_re_preg0", 32'(alloc_preg[0]), 32'd34);
    chk("fl_re_preg1", 32'(alloc_preg[1]), 32'd35);
    tick();
    chk("fl_re_free", 32'(free_count), 32'd30);
    drive(2'b11, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0);
    chk("fl_next_preg0", 32'(alloc_preg[0]), 32'd36);
    chk("fl_next_preg1", 32'(alloc_preg[1]), 32'd37);
    tick();

    // wrap: alternate 2-alloc and 2-push (pushed back swapped) across the ring end
    drive(2'b00, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    free_set = {32'hFFFF_FFFF, 32'h0};
    for (int k = 0; k < 20; k++) begin
      int e0;
      int e1;
      if (k < 16) begin
        e0 = 32 + 2 * k;
        e1 = 33 + 2 * k;
      end else begin
        e0 = 33 + 2 * (k - 16);
        e1 = 32 + 2 * (k - 16);
      end
      drive(2'b11, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0);
      chk("wrap_gnt", 32'(alloc_gnt), 32'd3);
      chk("wrap_preg0", 32'(alloc_preg[0]), 32'(e0));
      chk("wrap_preg1", 32'(alloc_preg[1]), 32'(e1));
      chk("wrap_sb_free0", 32'(free_set[alloc_preg[0]]), 32'd1);
      free_set[alloc_preg[0]] = 1'b0;
      chk("wrap_sb_free1", 32'(free_set[alloc_preg[1]]), 32'd1);
      free_set[alloc_preg[1]] = 1'b0;
      tick();
      chk("wrap_cnt_alloc", 32'(free_count), 32'($countones(free_set)));
      drive(2'b00, 2'b11, 6'(e1), 6'(e0), 2'b11, 1'b0);
      chk("wrap_sb_live0", 32'(free_set[e1]), 32'd0);
      chk("wrap_sb_live1", 32'(free_set[e0]), 32'd0);
      free_set[e0] = 1'b1;
      free_set[e1] = 1'b1;
      tick();
      chk("wrap_cnt_push", 32'(free_count), 32'($countones(free_set)));
    end
    chk("wrap_total", 32'($countones(free_set)), 32'd32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/phys_free_list_ctrl.md
Name: phys_free_list_ctrl

Overview:
- Manages the pool of free physical registers in the rename stage.
- Arbitrates allocation between SS in-order dispatch slots and accepts freed tags from up to SS retiring instructions per cycle.
- Keeps a retired-head pointer so a pipeline flush restores the pool in one cycle, consistent with the retired RAT snapshot.
- Implemented as a circular buffer of DEPTH = NUM_PREGS - NUM_AREGS tags.

Parameters:
- SS, 2: superscalar width, i.e. number of alloc slots and retire slots.
- NUM_PREGS, 64: physical register count. Tag width PW = $clog2(NUM_PREGS) = 6.
- NUM_AREGS, 32: architectural register count. DEPTH = NUM_PREGS - NUM_AREGS = 32.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- alloc_req  in  [SS] x 1  dispatch slot i needs a new physical reg (rd != x0); slot 0 is oldest
- alloc_gnt  out  [SS] x 1  slot i is granted this cycle
- alloc_preg  out  [SS] x PW  tag for slot i; valid only when alloc_gnt[i]
- retire_push  in  [SS] x 1  retire slot i frees a tag (the old mapping from the retired RAT)
- retire_preg  in  [SS] x PW  tag being freed by retire slot i
- retire_adv  in  [SS] x 1  retiring instr i originally allocated a tag; advances the retired head
- flush  in  1  mispredict/exception recovery
- free_count  out  $clog2(DEPTH)+1  number of free tags (0..DEPTH)
- empty  out  1  free_count == 0

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - ring[k] = NUM_AREGS + k for k in 0..DEPTH-1.
  - head = tail = rhead = 0, free_count = DEPTH, empty = 0, alloc_gnt = 0.
- Pointers: head, tail and rhead are log2(DEPTH)+1 bits wide; the MSB is a wrap bit, and all index arithmetic is mod DEPTH.
- Allocation is combinational from registered state.
  - Let n_i = number of set alloc_req in slots 0..i.
  - alloc_gnt[i] = alloc_req[i] && n_i <= free_count && !flush.
  - Grants are in order: when slot j is denied, every requesting slot above j is also denied (stall point).
  - alloc_preg[i] = ring[head + n_i - 1].
  - head advances by the number of grants at the clock edge.
- Retire push:
  - Slots are processed in index order. Slot i writes ring[tail + m_i - 1], where m_i = number of set retire_push in slots 0..i.
  - tail advances by the total number of pushes.
  - Pushed tags are not visible to allocation until the next cycle (no bypass).
- Retired head: rhead advances by popcount(retire_adv). Invariant: rhead is between tail and head, inclusive.
- free_count next = free_count + pushes - grants.
  - free_count is held in a register, not recomputed from pointers.
  - Simultaneous push and grant in one cycle are both applied.
- Flush:
  - head <= rhead + popcount(retire_adv).
  - free_count <= DEPTH.
  - Pushes and retire_adv in the flush cycle are still applied; tail updates normally.
  - alloc_gnt is forced to 0 in the flush cycle.
  - Flush has priority over allocation. rst has priority over flush.
- Overflow (push while free_count + pushes > DEPTH) and underflow are illegal.
  - The bench asserts against them.
  - RTL saturates free_count and drops the excess push.
- Retire of x0 never pushes. The retire stage guarantees this; the block does not filter.
- Reset mid-operation: all state returns to reset values on the next edge, regardless of in-flight requests.
- Wrap-around: pointers wrap mod DEPTH while the wrap bit toggles. Indices for grants or pushes that straddle the end of the ring wrap correctly within a single cycle.

Test Plan:
- After reset, alloc_req = 2'b11 for 1 cycle -> alloc_gnt = 11, pregs 32 and 33; next cycle free_count = 30.
- 16 cycles of double alloc (32 tags) -> free_count = 0 and empty = 1. Next alloc_req = 11 -> alloc_gnt = 00.
- free_count = 1 with alloc_req = 11 -> gnt = 01, preg 63. With alloc_req = 10 -> gnt = 10 and slot 1 receives the tag.
- Same cycle: 2 allocs, push tags 5 and 7, free_count = 2 -> grants succeed and free_count stays 2. Later allocs return 5 then 7, after the remaining ring contents.
- 4 allocs, 2 retired (retire_adv = 11, pushes 3 and 4), then flush -> free_count = 32. Next allocs return the tags freed by the 2 unretired (flushed) allocs first, then continue in ring order.
- Wrap: 40 cycles of alternating 2-alloc and 2-push -> no tag is duplicated or lost. Scoreboard: the set of free tags plus live tags always equals the 32 non-architectural tags.
